// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 8-digit seven-segment driver.
// Captures a 32-bit hex value plus blank/dp masks on a load strobe, swaps them
// into the display registers only at a frame boundary, and scans the digits
// with a leading all-anodes-off guard gap in every slot.
module seg7_scan_driver #(
    parameter int CLK_DIV = 100000,
    parameter int GUARD   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        frame_tick
);

    localparam int              CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   GUARD_END = CW'(GUARD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   disp_q, disp_d;
    logic [7:0]    blank_disp_q, blank_disp_d;
    logic [7:0]    dp_disp_q, dp_disp_d;
    logic [31:0]   pending_q, pending_d;
    logic [7:0]    pending_blank_q, pending_blank_d;
    logic [7:0]    pending_dp_q, pending_dp_d;
    logic          pending_valid_q, pending_valid_d;
    logic [7:0]    seg_q, seg_d;
    logic [7:0]    an_q, an_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    nib;
    logic          in_guard;

    // Active-low g..a pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Scan timing, load capture and frame-boundary swap of the display registers.
    always_comb begin
        slot_end        = (cnt_q == CNT_LAST);
        frame_end       = slot_end && (idx_q == 3'd7);
        cnt_d           = slot_end ? '0 : cnt_q + 1'b1;
        idx_d           = slot_end ? idx_q + 3'd1 : idx_q;
        disp_d          = disp_q;
        blank_disp_d    = blank_disp_q;
        dp_disp_d       = dp_disp_q;
        pending_d       = pending_q;
        pending_blank_d = pending_blank_q;
        pending_dp_d    = pending_dp_q;
        pending_valid_d = pending_valid_q;
        frame_tick_d    = frame_end;

        if (load) begin
            pending_d       = data_in;
            pending_blank_d = blank_mask;
            pending_dp_d    = dp_mask;
            pending_valid_d = 1'b1;
        end

        // A load coinciding with the wrap edge goes straight to the display,
        // so nothing is left pending for the following boundary.
        if (frame_end) begin
            if (load) begin
                disp_d          = data_in;
                blank_disp_d    = blank_mask;
                dp_disp_d       = dp_mask;
                pending_valid_d = 1'b0;
            end else if (pending_valid_q) begin
                disp_d          = pending_q;
                blank_disp_d    = pending_blank_q;
                dp_disp_d       = pending_dp_q;
                pending_valid_d = 1'b0;
            end
        end
    end

    // Segment/anode drive for the current slot, dark during the guard gap or when blanked.
    always_comb begin
        nib      = disp_q[{idx_q, 2'b00} +: 4];
        in_guard = (cnt_q < GUARD_END);
        seg_d    = 8'hFF;
        an_d     = 8'hFF;
        if (!in_guard && !blank_disp_q[idx_q]) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = {~dp_disp_q[idx_q], hex7(nib)};
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            disp_q          <= '0;
            blank_disp_q    <= '0;
            dp_disp_q       <= '0;
            pending_q       <= '0;
            pending_blank_q <= '0;
            pending_dp_q    <= '0;
            pending_valid_q <= 1'b0;
            seg_q           <= '1;
            an_q            <= '1;
            frame_tick_q    <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            disp_q          <= disp_d;
            blank_disp_q    <= blank_disp_d;
            dp_disp_q       <= dp_disp_d;
            pending_q       <= pending_d;
            pending_blank_q <= pending_blank_d;
            pending_dp_q    <= pending_dp_d;
            pending_valid_q <= pending_valid_d;
            seg_q           <= seg_d;
            an_q            <= an_d;
            frame_tick_q    <= frame_tick_d;
        end
    end

    assign SEG        = seg_q;
    assign AN         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
